// File: rtl/sound_pkg.sv
// Shared types and default constants for the sound blocks: FSM state encoding,
// default tone timing, and the per-source half-period helper.
package sound_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TONE   = 3'd1,
        GAP    = 3'd2,
        MELODY = 3'd3,
        DONE   = 3'd4
    } tone_state_t;

    localparam int unsigned BASE_HALF  = 25000;
    localparam int unsigned GO_HALF    = 5000;
    localparam int unsigned NOTE_TICKS = 2500000;
    localparam int unsigned GAP_TICKS  = 500000;

    // Half-period for event source i; only evaluated on constants, so no divider is built.
    function automatic int unsigned half_for_src(input int unsigned i, input int unsigned base);
        return base / (i + 1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tone_sequencer_square_gen.sv
// Square-wave generator: half-period down-counter plus toggle flop, restarted
// low on every load so each note begins with a clean phase.
module square_gen #(
    parameter int unsigned DIV_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] half,
    input  logic             en,
    output logic             wave
);

    logic [DIV_W-1:0] cnt;

    // half is the live half-period of the current note and also the reload value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (load) begin
            cnt  <= half - DIV_W'(1);
            wave <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= half - DIV_W'(1);
            wave <= ~wave;
        end else begin
            cnt  <= cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Sound-event tone sequencer: prioritised event tones plus a game-over melody,
// driving the buzzer pin directly. Optional macro TONE_SEQ_MELODY_LOOP_EN makes
// the melody repeat while game_over stays high instead of holding in DONE.
module tone_sequencer #(
    parameter int unsigned DIV_W      = 15,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned BASE_HALF  = sound_pkg::BASE_HALF,
    parameter int unsigned GO_HALF    = sound_pkg::GO_HALF,
    parameter int unsigned MELODY_LEN = 4,
    parameter int unsigned NOTE_TICKS = sound_pkg::NOTE_TICKS,
    parameter int unsigned GAP_TICKS  = sound_pkg::GAP_TICKS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic               game_over,
    input  logic               mute,
    output logic               buzzer,
    output logic               busy,
    output logic [DIV_W-1:0]   cur_half
);

    import sound_pkg::*;

    localparam int unsigned SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned SRC_TAB_N = 1 << SRC_W;
    localparam int unsigned MAX_TICKS = max_u(NOTE_TICKS, GAP_TICKS);
    localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [2:0]       MEL_LAST  = 3'(MELODY_LEN - 1);

    if (MELODY_LEN < 1 || MELODY_LEN > 8) begin : g_bad_melody_len
        $error("tone_sequencer: MELODY_LEN must be 1..8");
    end
    if ((longint'(GO_HALF) * longint'(MELODY_LEN)) > ((longint'(1) << DIV_W) - 1)) begin : g_bad_go_half
        $error("tone_sequencer: GO_HALF*MELODY_LEN does not fit DIV_W");
    end
    if (longint'(BASE_HALF) > ((longint'(1) << DIV_W) - 1)) begin : g_bad_base_half
        $error("tone_sequencer: BASE_HALF does not fit DIV_W");
    end
    if (NOTE_TICKS < 1 || GAP_TICKS < 1) begin : g_bad_ticks
        $error("tone_sequencer: NOTE_TICKS and GAP_TICKS must be at least 1");
    end

    // Constant half-period tables, padded to power-of-two depth so indices are exact-width.
    logic [DIV_W-1:0] src_tab [SRC_TAB_N];
    logic [DIV_W-1:0] mel_tab [8];

    for (genvar g = 0; g < SRC_TAB_N; g++) begin : g_src_tab
        if (g < NUM_SRC) begin : g_used
            assign src_tab[g] = DIV_W'(half_for_src(g, BASE_HALF));
        end else begin : g_pad
            assign src_tab[g] = '0;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_mel_tab
        if (g < MELODY_LEN) begin : g_used
            assign mel_tab[g] = DIV_W'(GO_HALF * (g + 1));
        end else begin : g_pad
            assign mel_tab[g] = '0;
        end
    end

    logic [SRC_W-1:0] sel;
    logic             any_req;

    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_req[i]) sel = SRC_W'(i);
        end
    end

    assign any_req = |src_req;

    tone_state_t      state, state_n;
    logic [SRC_W-1:0] cur_src, src_n;
    logic [2:0]       note_k, k_n;
    logic [CNT_W-1:0] dur_cnt, dur_n;
    logic [DIV_W-1:0] half_n;
    logic             load;

    always_comb begin
        state_n = state;
        src_n   = cur_src;
        k_n     = note_k;
        dur_n   = dur_cnt + CNT_W'(1);
        half_n  = cur_half;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                dur_n = '0;
                if (game_over) begin
                    state_n = MELODY;
                    k_n     = '0;
                    half_n  = mel_tab[0];
                    load    = 1'b1;
                end else if (any_req) begin
                    state_n = TONE;
                    src_n   = sel;
                    half_n  = src_tab[sel];
                    load    = 1'b1;
                end
            end
            TONE: begin
                if (game_over) begin
                    state_n = MELODY;
                    k_n     = '0;
                    dur_n   = '0;
                    half_n  = mel_tab[0];
                    load    = 1'b1;
                end else if (any_req && sel <= cur_src) begin
                    src_n  = sel;
                    dur_n  = '0;
                    half_n = src_tab[sel];
                    load   = 1'b1;
                end else if (dur_cnt == NOTE_LAST) begin
                    state_n = IDLE;
                    dur_n   = '0;
                    half_n  = '0;
                end
            end
            MELODY: begin
                if (!game_over) begin
                    state_n = IDLE;
                    dur_n   = '0;
                    half_n  = '0;
                end else if (dur_cnt == NOTE_LAST) begin
                    dur_n  = '0;
                    half_n = '0;
`ifdef TONE_SEQ_MELODY_LOOP_EN
                    state_n = GAP;
`else
                    state_n = (note_k == MEL_LAST) ? DONE : GAP;
`endif
                end
            end
            GAP: begin
                if (!game_over) begin
                    state_n = IDLE;
                    dur_n   = '0;
                end else if (dur_cnt == GAP_LAST) begin
                    state_n = MELODY;
                    dur_n   = '0;
                    k_n     = (note_k == MEL_LAST) ? 3'd0 : note_k + 3'd1;
                    half_n  = mel_tab[k_n];
                    load    = 1'b1;
                end
            end
            DONE: begin
                dur_n = '0;
                if (!game_over) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                dur_n   = '0;
                half_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_src  <= '0;
            note_k   <= '0;
            dur_cnt  <= '0;
            cur_half <= '0;
        end else begin
            state    <= state_n;
            cur_src  <= src_n;
            note_k   <= k_n;
            dur_cnt  <= dur_n;
            cur_half <= half_n;
        end
    end

    logic wave;
    logic playing;

    assign playing = (state == TONE) || (state == MELODY);

    square_gen #(
        .DIV_W(DIV_W)
    ) u_square_gen (
        .clk (clk),
        .rst (rst),
        .load(load),
        .half(half_n),
        .en  (playing),
        .wave(wave)
    );

    // Mute gates only the pin; note timing carries on underneath.
    assign buzzer = wave & ~mute;
    assign busy   = (state != IDLE);

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised successor to the sound-event frequency mapper.
- Arbitrates between NUM_SRC sound-event request lines and a game-over condition.
- Times each note for a fixed duration, then drives the buzzer pin directly with a square wave.
- Game over plays a descending multi-note melody rather than a single fixed tone.
- Sits between game logic (eat/power/ghost/move events) and the board's buzzer output.

Parameters:
- DIV_W, 15: width of the half-period counter and of cur_half.
- NUM_SRC, 4: number of event request lines. Index 0 has the highest priority.
- BASE_HALF, 25000: half-period in clocks for source 0. Source i uses BASE_HALF/(i+1), integer-truncated at elaboration.
- GO_HALF, 5000: half-period of game-over melody note 0. Note k uses GO_HALF*(k+1).
- MELODY_LEN, 4: number of game-over notes, 1..8.
- NOTE_TICKS, 2500000: note duration in clocks.
- GAP_TICKS, 500000: silence between melody notes, in clocks.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- src_req  in  NUM_SRC  event request pulses; any width accepted, sampled every cycle
- game_over  in  1  level; high while game is over
- mute  in  1  level; forces buzzer low, does not stop timing
- buzzer  out  1  square-wave output, registered
- busy  out  1  high in any state other than IDLE
- cur_half  out  DIV_W  half-period of the note being played; 0 when silent

Behaviour:
- Reset, synchronous, wins over everything:
  - state=IDLE.
  - buzzer=0, busy=0, cur_half=0.
  - All counters 0, cur_src=0, note index=0.
  - Reset mid-note aborts the note; there is no tail.
- States: IDLE, TONE, GAP, MELODY, DONE.
- Arbitration: sel = lowest set index of src_req.
- IDLE:
  - game_over=1 -> MELODY with k=0. This takes precedence over src_req.
  - Else any src_req bit -> TONE with cur_src=sel.
- TONE:
  - game_over=1 -> MELODY, k=0. The tone is abandoned the same cycle.
  - Else a request with sel <= cur_src restarts TONE with cur_src=sel and a full NOTE_TICKS.
  - Requests with sel > cur_src are dropped, not queued.
  - When the duration counter reaches NOTE_TICKS-1 -> IDLE.
- MELODY:
  - Plays note k for NOTE_TICKS.
  - Then -> GAP if k < MELODY_LEN-1, else -> DONE.
  - game_over falling in MELODY or GAP -> IDLE next cycle.
- GAP:
  - Silent for GAP_TICKS, then -> MELODY with k+1.
- DONE:
  - Silent; src_req ignored.
  - game_over=0 -> IDLE.
- Square wave:
  - On every note entry (including a TONE restart): half counter=cur_half-1 and buzzer=0.
  - Counter decrements each cycle. At 0 it reloads cur_half-1 and buzzer toggles.
  - Period is 2*cur_half clocks.
  - The first rising edge occurs cur_half clocks after the entry cycle.
- Latency: request sampled in cycle n -> state and cur_half updated at edge n+1. buzzer stays 0 until the first toggle.
- buzzer = toggle register AND NOT mute. cur_half is unaffected by mute.
- cur_half = 0 in IDLE, GAP and DONE.
- Widths:
  - Table values must fit DIV_W. GO_HALF*MELODY_LEN > 2^DIV_W-1 is an elaboration error via a generate-time check.
  - Duration counters are $clog2(max(NOTE_TICKS, GAP_TICKS)) bits.

Optional Feature:
- Macro: TONE_SEQ_MELODY_LOOP_EN.
- Defined: after the last melody note the block enters GAP, then MELODY with k=0, repeating while game_over=1. DONE is unreachable.
- Undefined: the melody plays once, then the block holds in DONE until game_over=0.

Decomposition:
- Shared package sound_pkg holds:
  - state enum tone_state_t.
  - Default constants BASE_HALF, GO_HALF, NOTE_TICKS, GAP_TICKS.
  - Function half_for_src(i) returning BASE_HALF/(i+1).
- One sub-module: square_gen.
  - Inputs: clk, rst, load, half, en.
  - Output: wave.
  - Owns the half-period counter and toggle flop.
- The FSM, arbiter and duration counters stay in tone_sequencer.

Test Plan (BASE_HALF=24, GO_HALF=5, MELODY_LEN=3, NOTE_TICKS=100, GAP_TICKS=20, NUM_SRC=4):
- src_req=4'b0100 for 1 cycle -> cur_half=8 next cycle, busy=1; buzzer rises 8 clks after entry, period 16; returns to IDLE after 100 clks with buzzer=0 and cur_half=0.
- src_req=4'b0010 during TONE with cur_src=2 -> restart: cur_half=12, fresh 100-clk duration. src_req=4'b1000 during that tone -> ignored, cur_half stays 12.
- src_req=4'b1010 in IDLE -> cur_src=1, cur_half=12.
- game_over=1 during TONE -> MELODY the next cycle with cur_half=5. Sequence: 5 (100 clks), 0 (20), 10 (100), 0 (20), 15 (100), then DONE with busy=1. game_over=0 -> IDLE.
- mute=1 throughout a tone -> buzzer constantly 0, cur_half=8, still ends after 100 clks.
- rst pulse mid-melody -> next cycle IDLE, buzzer=0, busy=0. With game_over still 1, MELODY restarts at k=0. With TONE_SEQ_MELODY_LOOP_EN defined, the sequence after note 15 is gap, then 5 again.
